// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: opcodes, argument prompt and FSM state type shared by the SPI command counter.
package spi_cmd_pkg;
  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_INC      = 8'h01;
  localparam logic [7:0] OP_DEC      = 8'h02;
  localparam logic [7:0] OP_LOAD     = 8'h03;
  localparam logic [7:0] OP_CLEAR    = 8'h04;
  localparam logic [7:0] OP_STATUS   = 8'h05;
  localparam logic [7:0] LOAD_PROMPT = 8'hA5;
  typedef enum logic [1:0] {IDLE, CMD, ARG} state_t;
endpackage

// File: rtl/spi_cmd_counter_if.sv
// spi_cmd_counter_if: byte stream from the SPI slave plus the counter's response and display outputs.
interface spi_cmd_counter_if #(parameter int WIDTH = 8);
  logic             cs_active;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic [7:0]       tx_data;
  logic [WIDTH-1:0] count;
  logic [4:0]       led;
  logic             err;
  modport slave (input cs_active, rx_valid, rx_data, output tx_data, count, led, err);
  modport master(output cs_active, rx_valid, rx_data, input tx_data, count, led, err);
endinterface

// File: rtl/spi_count_core.sv
// spi_count_core: WIDTH-bit up/down/load/clear counter; SPI_CMD_SAT_EN makes INC/DEC saturate instead of wrap.
module spi_count_core #(parameter int WIDTH = 8) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count,
  output logic [WIDTH-1:0] o_next
);
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_up;
  logic [WIDTH-1:0] w_dn;
`ifdef SPI_CMD_SAT_EN
  assign w_up = &r_count ? r_count : r_count + 1'b1;
  assign w_dn = ~|r_count ? r_count : r_count - 1'b1;
`else
  assign w_up = r_count + 1'b1;
  assign w_dn = r_count - 1'b1;
`endif
  // strobes are one-hot, so priority order is irrelevant
  assign o_next = i_clr ? '0 : i_load ? i_load_val : i_inc ? w_up : i_dec ? w_dn : r_count;
  always_ff @(posedge clk)
    if (!rst_n) r_count <= '0;
    else r_count <= o_next;
  assign o_count = r_count;
endmodule

// File: rtl/spi_cmd_counter.sv
// spi_cmd_counter: decodes SPI command bytes into counter operations and builds the MISO response byte.
// Build with SPI_CMD_SAT_EN defined for saturating INC/DEC.
module spi_cmd_counter
  import spi_cmd_pkg::*;
#(parameter int WIDTH = 8) (
  input logic             clk,
  input logic             rst_n,
  spi_cmd_counter_if.slave bus
);
  state_t           r_state;
  state_t           w_after;
  state_t           w_state_next;
  logic             r_err;
  logic [7:0]       r_tx;
  logic             w_proc;
  logic             w_cmd;
  logic             w_inc;
  logic             w_dec;
  logic             w_load;
  logic             w_clr;
  logic             w_bad;
  logic             w_err_next;
  logic [7:0]       w_tx_next;
  logic [WIDTH-1:0] w_count;
  logic [WIDTH-1:0] w_next_count;
  assign w_proc = bus.rx_valid && r_state != IDLE;
  always_ff @(posedge clk)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_state_next;
  // w_after is where this byte leaves us; losing CS while it is ARG aborts the LOAD
  always_comb begin
    w_after      = w_proc ? ((r_state == CMD && bus.rx_data == OP_LOAD) ? ARG : CMD) : r_state;
    w_state_next = !bus.cs_active ? IDLE : (r_state == IDLE ? CMD : w_after);
  end
  always_comb begin
    w_cmd      = w_proc && r_state == CMD;
    w_inc      = w_cmd && bus.rx_data == OP_INC;
    w_dec      = w_cmd && bus.rx_data == OP_DEC;
    w_clr      = w_cmd && bus.rx_data == OP_CLEAR;
    w_load     = w_proc && r_state == ARG;
    w_bad      = w_cmd && bus.rx_data > OP_STATUS;
    w_err_next = w_clr ? 1'b0 : (w_bad || (!bus.cs_active && w_after == ARG)) ? 1'b1 : r_err;
    w_tx_next  = !w_proc ? r_tx :
                 (w_cmd && bus.rx_data == OP_STATUS) ? {7'b0, r_err} :
                 (w_cmd && bus.rx_data == OP_LOAD) ? LOAD_PROMPT : 8'(w_next_count);
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_err <= 1'b0;
      r_tx  <= 8'h00;
    end else begin
      r_err <= w_err_next;
      r_tx  <= w_tx_next;
    end
  spi_count_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_inc     (w_inc),
    .i_dec     (w_dec),
    .i_load    (w_load),
    .i_load_val(bus.rx_data[WIDTH-1:0]),
    .i_clr     (w_clr),
    .o_count   (w_count),
    .o_next    (w_next_count)
  );
  assign bus.count   = w_count;
  assign bus.led     = w_count[4:0];
  assign bus.err     = r_err;
  assign bus.tx_data = r_tx;
endmodule

// File: tb/tb_spi_cmd_counter.sv
// tb_spi_cmd_counter: directed vector table, corner sequences and random traffic against a behavioural model.
module tb_spi_cmd_counter;
  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;
`ifdef SPI_CMD_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int DEC0 = SAT ? 0 : MAXV;
  typedef struct {
    bit       rst_n;
    bit       cs;
    bit       v;
    bit [7:0] d;
    int       count;
    int       err;
    int       tx;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  spi_cmd_counter_if #(.WIDTH(W)) bus();
  spi_cmd_counter #(.WIDTH(W)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int m_mode, m_count, m_err, m_tx;
  vec_t tbl[$];
  // mode: 0 = idle, 1 = waiting for opcode, 2 = waiting for LOAD argument
  task automatic model(bit r, bit cs, bit v, int d);
    int after;
    if (!r) begin
      m_mode = 0; m_count = 0; m_err = 0; m_tx = 0;
      return;
    end
    after = m_mode;
    if (v && m_mode != 0) begin
      after = 1;
      if (m_mode == 2) m_count = d & MAXV;
      else if (d == 1) m_count = (SAT && m_count == MAXV) ? m_count : (m_count + 1) & MAXV;
      else if (d == 2) m_count = (SAT && m_count == 0) ? 0 : (m_count - 1) & MAXV;
      else if (d == 3) after = 2;
      else if (d == 4) begin m_count = 0; m_err = 0; end
      else if (d > 5) m_err = 1;
      m_tx = (m_mode == 1 && d == 3) ? 'hA5 : (m_mode == 1 && d == 5) ? m_err : m_count;
    end
    if (!cs) begin
      if (after == 2) m_err = 1;
      m_mode = 0;
    end else m_mode = (m_mode == 0) ? 1 : after;
  endtask
  task automatic step(bit r, bit cs, bit v, bit [7:0] d);
    rst_n = r; bus.cs_active = cs; bus.rx_valid = v; bus.rx_data = d;
    @(posedge clk);
    model(r, cs, v, int'(d));
    #1;
  endtask
  task automatic chk(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask
  task automatic chk_all(string tag, int c, int e, int t);
    chk({tag, " count"}, int'(bus.count), c);
    chk({tag, " led"}, int'(bus.led), c & 31);
    chk({tag, " err"}, int'(bus.err), e);
    chk({tag, " tx"}, int'(bus.tx_data), t);
  endtask
  initial begin
    bus.cs_active = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    tbl.push_back('{0, 0, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{1, 1, 1, 8'h01, 1, 0, 1});
    tbl.push_back('{1, 1, 1, 8'h01, 2, 0, 2});
    tbl.push_back('{1, 1, 1, 8'h01, 3, 0, 3});
    tbl.push_back('{1, 0, 0, 8'h00, 3, 0, 3});
    tbl.push_back('{1, 1, 0, 8'h00, 3, 0, 3});
    tbl.push_back('{1, 1, 1, 8'h03, 3, 0, 'hA5});
    tbl.push_back('{1, 1, 1, 8'h7E, 'h7E, 0, 'h7E});
    tbl.push_back('{1, 0, 0, 8'h00, 'h7E, 0, 'h7E});
    tbl.push_back('{1, 1, 0, 8'h00, 'h7E, 0, 'h7E});
    tbl.push_back('{1, 1, 1, 8'h03, 'h7E, 0, 'hA5});
    tbl.push_back('{1, 0, 0, 8'h00, 'h7E, 1, 'hA5});
    tbl.push_back('{1, 1, 0, 8'h00, 'h7E, 1, 'hA5});
    tbl.push_back('{1, 1, 1, 8'h05, 'h7E, 1, 1});
    tbl.push_back('{1, 1, 1, 8'h04, 0, 0, 0});
    tbl.push_back('{1, 1, 1, 8'h02, DEC0, 0, DEC0});
    tbl.push_back('{1, 1, 1, 8'h04, 0, 0, 0});
    tbl.push_back('{1, 1, 1, 8'h9C, 0, 1, 0});
    tbl.push_back('{1, 0, 1, 8'h01, 1, 1, 1});
    tbl.push_back('{1, 0, 1, 8'h01, 1, 1, 1});
    tbl.push_back('{1, 1, 1, 8'h01, 1, 1, 1});
    tbl.push_back('{1, 1, 1, 8'h03, 1, 1, 'hA5});
    tbl.push_back('{0, 1, 1, 8'h55, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{1, 1, 1, 8'h7E, 0, 1, 0});
    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].cs, tbl[i].v, tbl[i].d);
      chk_all($sformatf("vec%0d", i), tbl[i].count, tbl[i].err, tbl[i].tx);
    end
    step(1, 1, 1, 8'h04); chk_all("clr", 0, 0, 0);
    step(1, 1, 1, 8'h03); chk_all("load op", 0, 0, 'hA5);
    step(1, 0, 1, 8'h2A); chk_all("arg with cs fall", 'h2A, 0, 'h2A);
    step(1, 0, 0, 8'h00); chk_all("idle after arg", 'h2A, 0, 'h2A);
    step(1, 1, 1, 8'h01); chk_all("reassert ignores", 'h2A, 0, 'h2A);
    step(1, 1, 1, 8'h01); chk_all("first byte", 'h2B, 0, 'h2B);
    for (int n = 0; n < 3000; n++) begin
      int k;
      bit [7:0] d;
      k = int'($urandom % 10);
      d = (k < 7) ? 8'(k % 6) : (k == 7) ? 8'h03 : 8'($urandom);
      step(($urandom % 150) != 0, ($urandom % 10) != 0, ($urandom % 3) != 0, d);
      chk_all($sformatf("rnd%0d", n), m_count, m_err, m_tx);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_cmd_counter.md
# spi_cmd_counter

Command-decode and counter stage directly downstream of the iCEstick SPI slave. It consumes each byte the slave deserialises from MOSI, interprets it as a counter command, and holds an up/down counter whose low bits drive LEDs D1–D5. It returns a response byte to the slave for shifting out on MISO during the next byte slot.

## Interface

Parameters:
- `WIDTH`, default 8: counter width. Legal range 5..8.

Ports:
- `clk`  in  1: system clock (iCEstick 12 MHz).
- `rst_n`  in  1: synchronous, active-low reset.
- `cs_active`  in  1: chip select asserted, already synchronised to `clk` by the SPI slave.
- `rx_valid`  in  1: one-cycle pulse; `rx_data` is valid in that cycle.
- `rx_data`  in  8: received byte.
- `tx_data`  out  8: response byte. The slave samples it at the start of the next byte slot.
- `count`  out  WIDTH: counter value.
- `led`  out  5: equals `count[4:0]`, routed to D1..D5.
- `err`  out  1: sticky error flag.

## Operation

- Opcodes:
  - 0x00 NOP: no change.
  - 0x01 INC: count+1.
  - 0x02 DEC: count−1.
  - 0x03 LOAD: the next byte is the argument; `count <= rx_data[WIDTH-1:0]`.
  - 0x04 CLEAR: count=0 and err=0.
  - 0x05 STATUS: no counter change.
  - Any other value: `err <= 1`; count unchanged.
- FSM states:
  - IDLE: cs inactive. `rx_valid` is ignored.
  - CMD: awaiting an opcode.
  - ARG: awaiting the LOAD argument.
- FSM transitions:
  - IDLE→CMD when `cs_active`=1.
  - CMD→ARG on LOAD.
  - ARG→CMD on any byte. The argument byte is never decoded as an opcode.
  - Any state→IDLE when `cs_active`=0.
- Response byte:
  - After every processed byte, `tx_data` = new count, zero-extended to 8 bits.
  - Exception: after STATUS, `tx_data` = {7'b0, err}.
  - Exception: after the LOAD opcode byte, `tx_data` = 0xA5 (argument prompt).
- Arithmetic: modulo 2^WIDTH (INC at max→0, DEC at 0→max), unless the macro below is defined.
- Boundary cases:
  - `rx_valid` and falling `cs_active` in the same cycle: the byte is fully processed, then the FSM enters IDLE.
  - `cs_active` falls while in ARG: the LOAD is aborted, `err <= 1`, count unchanged.
  - `rx_valid` while `cs_active`=0: no state or output change.
  - `cs_active` re-asserts in the cycle directly after deassertion: the FSM passes through IDLE for one cycle, then enters CMD.
  - `err` stays set until CLEAR or reset.

## Timing

- All outputs are registered.
- `count`, `led`, `err`, `tx_data` and the FSM state update on the `clk` edge ending the `rx_valid` cycle (latency 1).
- Back-to-back `rx_valid` in consecutive cycles must be handled, one byte per cycle.
- Reset (`rst_n`=0 sampled at a `clk` edge) forces: state IDLE, count=0, led=0, err=0, `tx_data`=0x00.
- Reset overrides any concurrent `rx_valid`, including mid-frame and mid-LOAD.
- A new frame starts in CMD with `tx_data` holding its last value. The first MISO byte of a frame is the previous frame's final response.

## Configuration

- `SPI_CMD_SAT_EN`:
  - Defined: INC at 2^WIDTH−1 and DEC at 0 hold the count. `err` is not set.
  - Undefined: wrap-around as above.
- All other behaviour is identical in both builds.

## Structure

- Package `spi_cmd_pkg`:
  - Opcode constants: OP_NOP, OP_INC, OP_DEC, OP_LOAD, OP_CLEAR, OP_STATUS.
  - LOAD_PROMPT = 0xA5.
  - FSM state enum: IDLE, CMD, ARG.
- Sub-module `spi_count_core`: holds the WIDTH-bit counter.
  - Inputs: inc, dec, load, load_val, clr.
  - Contains the `SPI_CMD_SAT_EN` logic.
  - inc, dec, load and clr are one-hot; the decoder guarantees this.
- The top level keeps the FSM, opcode decode, `err` and `tx_data`.

## Test plan

- Reset, then frame: 0x01, 0x01, 0x01 → count=3, led=5'b00011, `tx_data` sequence 0x01, 0x02, 0x03.
- count=0, send 0x02 → count=0xFF and `tx_data`=0xFF without the macro; count=0x00 with `SPI_CMD_SAT_EN`.
- Frame 0x03, 0x7E → `tx_data` 0xA5 then 0x7E; count=0x7E; led=5'b11110.
- Frame ends after 0x03 only → err=1, count unchanged. Then 0x05 → `tx_data`=0x01. Then 0x04 → count=0, err=0.
- Opcode 0x9C → err=1, count unchanged. Also `rx_valid` with `cs_active`=0 → no change.
- Mid-LOAD `rst_n`=0 for one cycle together with `rx_valid` → all outputs zero. Next frame 0x7E is decoded as an opcode: err=1.
